crm_loader: RTL and testbench

- Write-side companion to the CRAM read path: loads microcode into the 2K x 84 CRAM storage from the diagnostic bus.
- The front end delivers each 84-bit microword as four 21-bit chunks. The block assembles them in a staging register, then issues a single-cycle write to the CRAM memory port.
- After each write the CRAM address auto-increments, so whole microcode images stream in with one address load.

---
 rtl/crm_loader.sv | 144 ++++++++++++++
 tb/tb_crm_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/crm_loader.sv
// crm_loader: loads 84-bit microwords into the 2K x 84 CRAM from the diagnostic bus.
// Four 21-bit chunks are assembled in a staging register, then written in one cycle.
// After each write the load pointer auto-increments.
// Build option: define CRM_LOADER_READBACK_EN to read each written word back and compare it.
`timescale 1ns/1ps
module crm_loader #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 84,
  parameter int unsigned CHUNK_W = 21
) (
  input  logic               eboxClk,
  input  logic               eboxReset,
  input  logic               diagStrobe,
  input  logic [1:0]         diagFunc,
  input  logic [CHUNK_W-1:0] diagData,
  output logic               busy,
  output logic               overrun,
  output logic [1:0]         chunkCount,
  output logic               cramWe,
  output logic [ADDR_W-1:0]  cramAddr,
  output logic [DATA_W-1:0]  cramDin,
  input  logic [DATA_W-1:0]  cramDout,
  output logic               mismatch
);

  localparam int unsigned F0_HI = DATA_W - 1;
  localparam int unsigned F1_HI = DATA_W - 1 - CHUNK_W;
  localparam int unsigned F2_HI = DATA_W - 1 - 2 * CHUNK_W;
  localparam int unsigned F3_HI = DATA_W - 1 - 3 * CHUNK_W;

`ifdef CRM_LOADER_READBACK_EN
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_CHECK} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_WRITE} state_t;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   stage_q, stage_d;
  logic [1:0]          count_q, count_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, we_q;
`ifdef CRM_LOADER_READBACK_EN
  logic                mismatch_q, mismatch_d;
`else
  logic                unused_dout;
  assign unused_dout = ^cramDout;
`endif

  // State and datapath registers; busy/cramWe are registered from the next state.
  always_ff @(posedge eboxClk or posedge eboxReset) begin
    if (eboxReset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      stage_q    <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
      we_q       <= 1'b0;
`ifdef CRM_LOADER_READBACK_EN
      mismatch_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stage_q    <= stage_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      busy_q     <= (state_d != S_IDLE);
      we_q       <= (state_d == S_WRITE);
`ifdef CRM_LOADER_READBACK_EN
      mismatch_q <= mismatch_d;
`endif
    end
  end

  // Command decode, chunk assembly and write/readback sequencing.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stage_d    = stage_q;
    count_d    = count_q;
    overrun_d  = overrun_q;
`ifdef CRM_LOADER_READBACK_EN
    mismatch_d = mismatch_q;
`endif
    if (diagStrobe && (state_q != S_IDLE)) overrun_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (diagStrobe) begin
          case (diagFunc)
            2'b00: begin
              addr_d  = diagData[ADDR_W-1:0];
              count_d = 2'd0;
            end
            2'b01: begin
              case (count_q)
                2'd0:    stage_d[F0_HI -: CHUNK_W] = diagData;
                2'd1:    stage_d[F1_HI -: CHUNK_W] = diagData;
                2'd2:    stage_d[F2_HI -: CHUNK_W] = diagData;
                default: stage_d[F3_HI -: CHUNK_W] = diagData;
              endcase
              count_d = count_q + 2'd1;
              if (count_q == 2'd3) state_d = S_WRITE;
            end
            2'b10: begin
              stage_d = '0;
              count_d = 2'd0;
            end
            default: ;
          endcase
        end
      end
`ifdef CRM_LOADER_READBACK_EN
      S_WRITE: state_d = S_READ;
      S_READ:  state_d = S_CHECK;
      S_CHECK: begin
        if (cramDout != stage_q) mismatch_d = 1'b1;
        addr_d  = addr_q + ADDR_W'(1);
        state_d = S_IDLE;
      end
`else
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign chunkCount = count_q;
  assign cramWe     = we_q;
  assign cramAddr   = addr_q;
  assign cramDin    = stage_q;
`ifdef CRM_LOADER_READBACK_EN
  assign mismatch   = mismatch_q;
`else
  assign mismatch   = 1'b0;
`endif

endmodule

// File: tb/tb_crm_loader.sv
// tb_crm_loader: directed and randomized checks of crm_loader against a word-level model.
`timescale 1ns/1ps
module tb_crm_loader;

`ifdef CRM_LOADER_READBACK_EN
  localparam int BUSY_CYC = 3;
`else
  localparam int BUSY_CYC = 1;
`endif

  logic        eboxClk = 1'b0;
  logic        eboxReset;
  logic        diagStrobe;
  logic [1:0]  diagFunc;
  logic [20:0] diagData;
  logic        busy, overrun, cramWe, mismatch;
  logic [1:0]  chunkCount;
  logic [10:0] cramAddr;
  logic [83:0] cramDin;
  logic [83:0] cramDout;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [10:0] m_addr;
  logic [20:0] m_chunk [4];
  int          m_cnt;
  bit          m_ovr, m_mis;
  int          m_writes = 0;
  bit          flip = 1'b0;

  logic [94:0] wlog [$];
  logic [83:0] mem [0:2047];

  crm_loader dut (
    .eboxClk(eboxClk), .eboxReset(eboxReset), .diagStrobe(diagStrobe),
    .diagFunc(diagFunc), .diagData(diagData), .busy(busy), .overrun(overrun),
    .chunkCount(chunkCount), .cramWe(cramWe), .cramAddr(cramAddr),
    .cramDin(cramDin), .cramDout(cramDout), .mismatch(mismatch)
  );

  always #5 eboxClk = ~eboxClk;

  // CRAM model with one-cycle read latency; optional bit-0 corruption on read
  always @(posedge eboxClk) begin
    if (cramWe === 1'b1) begin
      mem[cramAddr] <= cramDin;
      wlog.push_back({cramAddr, cramDin});
    end
    cramDout <= mem[cramAddr] ^ {83'b0, flip};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [83:0] stage();
    return {m_chunk[0], m_chunk[1], m_chunk[2], m_chunk[3]};
  endfunction

  task automatic m_reset();
    m_addr = '0;
    for (int k = 0; k < 4; k++) m_chunk[k] = '0;
    m_cnt = 0;
    m_ovr = 0;
    m_mis = 0;
  endtask

  task automatic chk(input string tag, input logic [94:0] obs, input logic [94:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic finish_word(input bit inject);
    int          cyc   = 1;
    bit          first = 1'b1;
    logic [10:0] waddr = m_addr;
    logic [83:0] wdata = stage();
    while (busy === 1'b1 && cyc < 10) begin
      @(negedge eboxClk);
      if (inject && first) begin
        diagStrobe = 1'b1; diagFunc = 2'b00; diagData = 21'h000555;
      end
      first = 1'b0;
      @(posedge eboxClk); #1;
      diagStrobe = 1'b0; diagFunc = 2'b11;
      if (busy === 1'b1) cyc++;
    end
    m_writes++;
    m_addr = m_addr + 11'd1;
    if (inject) m_ovr = 1;
`ifdef CRM_LOADER_READBACK_EN
    if (flip) m_mis = 1;
`endif
    chk("busy_cycles", 95'(cyc), 95'(BUSY_CYC));
    chk("addr_inc", 95'(cramAddr), 95'(m_addr));
    chk("busy_done", 95'(busy), 95'd0);
    chk("we_done", 95'(cramWe), 95'd0);
    chk("overrun", 95'(overrun), 95'(m_ovr));
    chk("mismatch", 95'(mismatch), 95'(m_mis));
    chk("nwrites", 95'(wlog.size()), 95'(m_writes));
    if (wlog.size() > 0) chk("wentry", wlog[$], {waddr, wdata});
  endtask

  task automatic apply(input logic [1:0] f, input logic [20:0] d, input bit inject);
    bit done = 1'b0;
    @(negedge eboxClk);
    diagStrobe = 1'b1; diagFunc = f; diagData = d;
    @(posedge eboxClk); #1;
    diagStrobe = 1'b0; diagFunc = 2'b11;
    case (f)
      2'b00: begin m_addr = d[10:0]; m_cnt = 0; end
      2'b01: begin
        m_chunk[m_cnt] = d;
        if (m_cnt == 3) begin m_cnt = 0; done = 1'b1; end
        else m_cnt++;
      end
      2'b10: begin
        for (int k = 0; k < 4; k++) m_chunk[k] = '0;
        m_cnt = 0;
      end
      default: ;
    endcase
    chk("count", 95'(chunkCount), 95'(m_cnt));
    chk("busy", 95'(busy), 95'(done));
    chk("we", 95'(cramWe), 95'(done));
    chk("addr", 95'(cramAddr), 95'(m_addr));
    chk("din", 95'(cramDin), 95'(stage()));
    if (done) finish_word(inject);
  endtask

  initial begin
    logic [83:0] t1_word;
    eboxReset = 1'b1; diagStrobe = 1'b0; diagFunc = 2'b11; diagData = '0;
    m_reset();
    #12;
    chk("rst_busy", 95'(busy), 95'd0);
    chk("rst_we", 95'(cramWe), 95'd0);
    chk("rst_addr", 95'(cramAddr), 95'd0);
    chk("rst_din", 95'(cramDin), 95'd0);
    chk("rst_cnt", 95'(chunkCount), 95'd0);
    chk("rst_ovr", 95'(overrun), 95'd0);
    chk("rst_mis", 95'(mismatch), 95'd0);
    @(negedge eboxClk); eboxReset = 1'b0;

    // 1: basic word at 0x123
    apply(2'b00, 21'h000123, 0);
    apply(2'b01, 21'h1FFFFF, 0);
    apply(2'b01, 21'h000001, 0);
    apply(2'b01, 21'h0AAAAA, 0);
    apply(2'b01, 21'h155555, 0);
    t1_word = {21'h1FFFFF, 21'h000001, 21'h0AAAAA, 21'h155555};
    chk("t1_entry", wlog[0], {11'h123, t1_word});
    chk("t1_addr", 95'(cramAddr), 95'h124);

    // 2: pointer wrap
    apply(2'b00, 21'h0007FF, 0);
    for (int i = 0; i < 4; i++) apply(2'b01, 21'($urandom), 0);
    chk("t2_wrap", 95'(cramAddr), 95'h000);

    // 3: partial load abandoned by an address load
    apply(2'b01, 21'h012345, 0);
    apply(2'b01, 21'h0ABCDE, 0);
    apply(2'b00, 21'h000010, 0);
    for (int i = 0; i < 4; i++) apply(2'b01, 21'($urandom), 0);
    chk("t3_addr", wlog[$][94:84], 95'h010);

    // 4: strobe while busy sets sticky overrun
    for (int i = 0; i < 3; i++) apply(2'b01, 21'($urandom), 0);
    apply(2'b01, 21'h03C3C3, 1);
    apply(2'b10, 21'h0, 0);
    chk("t4_sticky", 95'(overrun), 95'd1);

    // 6: readback compare (clean word, then corrupted word)
`ifdef CRM_LOADER_READBACK_EN
    for (int i = 0; i < 4; i++) apply(2'b01, 21'($urandom), 0);
    chk("t6_clean", 95'(mismatch), 95'd0);
    flip = 1'b1;
    for (int i = 0; i < 4; i++) apply(2'b01, 21'($urandom), 0);
    flip = 1'b0;
    chk("t6_flip", 95'(mismatch), 95'd1);
`endif

    // 5: asynchronous reset while cramWe is high
    for (int i = 0; i < 3; i++) apply(2'b01, 21'($urandom), 0);
    @(negedge eboxClk);
    diagStrobe = 1'b1; diagFunc = 2'b01; diagData = 21'h1ABCDE;
    @(posedge eboxClk); #1;
    diagStrobe = 1'b0; diagFunc = 2'b11;
    chk("t5_we_pre", 95'(cramWe), 95'd1);
    #2 eboxReset = 1'b1;
    #1;
    m_reset();
    chk("t5_we", 95'(cramWe), 95'd0);
    chk("t5_busy", 95'(busy), 95'd0);
    chk("t5_addr", 95'(cramAddr), 95'd0);
    chk("t5_cnt", 95'(chunkCount), 95'd0);
    chk("t5_ovr", 95'(overrun), 95'd0);
    @(negedge eboxClk); eboxReset = 1'b0;
    @(negedge eboxClk);
    chk("t5_nwrites", 95'(wlog.size()), 95'(m_writes));

    // randomized command stream
    for (int i = 0; i < 120; i++) begin
      logic [1:0] f;
      f = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) f = 2'b01;
      apply(f, 21'($urandom), ($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
